// File: rtl/led_blinker.sv
// led_blinker: drives an indicator pin with a burst of timed on/off pulses
// on request; phases are measured in milliseconds of the system clock.
module led_blinker #(
  parameter logic ACTIVE_STATE    = 1'b1,
  parameter int   CLOCKS_PER_USEC = 125,
  parameter int   ON_MSEC         = 100,
  parameter int   OFF_MSEC        = 100,
  parameter int   COUNT_WIDTH     = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic [COUNT_WIDTH-1:0] COUNT,
  input  logic                   STOP,
  output logic                   PIN,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int unsigned ON_PERIOD =
    CLOCKS_PER_USEC * ON_MSEC * 1000;
  localparam int unsigned OFF_PERIOD =
    CLOCKS_PER_USEC * OFF_MSEC * 1000;
  localparam int unsigned MAX_PERIOD =
    (ON_PERIOD > OFF_PERIOD) ? ON_PERIOD : OFF_PERIOD;
  localparam int TIMER_W = $clog2(MAX_PERIOD + 1);

  localparam logic [TIMER_W-1:0] ON_LOAD  = ON_PERIOD[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0] OFF_LOAD = OFF_PERIOD[TIMER_W-1:0];
  localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
  localparam logic [COUNT_WIDTH-1:0] C_ONE = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_d;
  logic [TIMER_W-1:0]     timer;
  logic [TIMER_W-1:0]     timer_d;
  logic [COUNT_WIDTH-1:0] remain;
  logic [COUNT_WIDTH-1:0] remain_d;
  logic                   done_d;
  logic                   expired;
  logic                   accept;

  // Timer holds the cycles left in the phase, including the current one.
  assign expired = (timer <= T_ONE);
  assign accept  = START && (COUNT != '0) && !STOP;

  always_comb begin
    state_d  = state;
    timer_d  = timer;
    remain_d = remain;
    done_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d  = ON;
          timer_d  = ON_LOAD;
          remain_d = COUNT;
        end
      end
      ON: begin
        if (STOP) begin
          state_d  = IDLE;
          timer_d  = '0;
          remain_d = '0;
        end else if (expired) begin
          state_d = OFF;
          timer_d = OFF_LOAD;
          if (remain != '0)
            remain_d = remain - C_ONE;
        end else begin
          timer_d = timer - T_ONE;
        end
      end
      OFF: begin
        if (STOP) begin
          state_d  = IDLE;
          timer_d  = '0;
          remain_d = '0;
        end else if (expired) begin
          if (remain != '0) begin
            state_d = ON;
            timer_d = ON_LOAD;
          end else begin
            state_d = IDLE;
            timer_d = '0;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer - T_ONE;
        end
      end
      default: begin
        state_d  = IDLE;
        timer_d  = '0;
        remain_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      timer  <= '0;
      remain <= '0;
      PIN    <= ~ACTIVE_STATE;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_d;
      timer  <= timer_d;
      remain <= remain_d;
      PIN    <= (state_d == ON) ? ACTIVE_STATE : ~ACTIVE_STATE;
      BUSY   <= (state_d != IDLE);
      DONE   <= done_d;
    end
  end

endmodule

// File: tb/tb_led_blinker.sv
// tb_led_blinker: random and scripted bursts on both pin polarities,
// checked every cycle against an arithmetic timeline model.
module tb_led_blinker;

  localparam int CPU   = 1;
  localparam int ON_MS = 1;
  localparam int OFF_MS = 2;
  localparam int ON_P  = CPU * ON_MS * 1000;
  localparam int OFF_P = CPU * OFF_MS * 1000;
  localparam int BLINK = ON_P + OFF_P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] count = '0;
  logic       pin_hi, busy_hi, done_hi;
  logic       pin_lo, busy_lo, done_lo;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  bit m_act = 1'b0;
  int m_t0  = 0;
  int m_n   = 0;

  always #5 clk = ~clk;

  led_blinker #(
    .ACTIVE_STATE(1'b1), .CLOCKS_PER_USEC(CPU),
    .ON_MSEC(ON_MS), .OFF_MSEC(OFF_MS), .COUNT_WIDTH(4)
  ) dut_hi (
    .CLK(clk), .RESET(rst), .START(start), .COUNT(count),
    .STOP(stop), .PIN(pin_hi), .BUSY(busy_hi), .DONE(done_hi)
  );

  led_blinker #(
    .ACTIVE_STATE(1'b0), .CLOCKS_PER_USEC(CPU),
    .ON_MSEC(ON_MS), .OFF_MSEC(OFF_MS), .COUNT_WIDTH(4)
  ) dut_lo (
    .CLK(clk), .RESET(rst), .START(start), .COUNT(count),
    .STOP(stop), .PIN(pin_lo), .BUSY(busy_lo), .DONE(done_lo)
  );

  task automatic check(input string tag, input logic got,
                       input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
  endtask

  // Position of cycle c inside the current burst timeline.
  function automatic int rel_of(input int c);
    return c - m_t0;
  endfunction

  function automatic bit m_busy(input int c);
    return m_act && rel_of(c) >= 1 && rel_of(c) <= m_n * BLINK;
  endfunction

  function automatic bit m_pin(input int c);
    if (!m_busy(c)) return 1'b0;
    return ((rel_of(c) - 1) % BLINK) < ON_P;
  endfunction

  function automatic bit m_done(input int c);
    return m_act && rel_of(c) == m_n * BLINK + 1;
  endfunction

  task automatic check_all();
    bit ep, eb, ed;
    ep = m_pin(cyc);
    eb = m_busy(cyc);
    ed = m_done(cyc);
    check("pin_hi", pin_hi, ep);
    check("pin_lo", pin_lo, ~ep);
    check("busy_hi", busy_hi, eb);
    check("busy_lo", busy_lo, eb);
    check("done_hi", done_hi, ed);
    check("done_lo", done_lo, ed);
  endtask

  task automatic model_update(input logic s, input logic [3:0] c,
                              input logic p, input logic r);
    if (r) begin
      m_act = 1'b0;
    end else if (m_busy(cyc)) begin
      if (p) m_act = 1'b0;
    end else if (s && c != 0 && !p) begin
      m_act = 1'b1;
      m_t0  = cyc;
      m_n   = int'(c);
    end
  endtask

  task automatic step(input logic s, input logic [3:0] c,
                      input logic p, input logic r);
    start = s;
    count = c;
    stop  = p;
    rst   = r;
    model_update(s, c, p, r);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
  endtask

  initial begin
    int w;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd3, 1'b0, 1'b1);
    idle(5);

    // single blink
    step(1'b1, 4'd1, 1'b0, 1'b0);
    idle(BLINK + 10);

    // burst of three
    step(1'b1, 4'd3, 1'b0, 1'b0);
    idle(3 * BLINK + 10);

    // count of zero, then a retrigger attempt mid-burst
    step(1'b1, 4'd0, 1'b0, 1'b0);
    idle(10);
    step(1'b1, 4'd2, 1'b0, 1'b0);
    w = $urandom_range(100, 4000);
    idle(w);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    idle(2 * BLINK - w + 10);

    // abort at T+1500, restart at T+1510
    step(1'b1, 4'd4, 1'b0, 1'b0);
    idle(1499);
    step(1'b0, 4'd4, 1'b1, 1'b0);
    idle(9);
    step(1'b1, 4'($urandom_range(1, 3)), 1'b0, 1'b0);
    idle(3 * BLINK + 10);

    // stop and start together in idle
    step(1'b1, 4'd2, 1'b1, 1'b0);
    idle(20);

    // stop on the final off-phase expiry
    step(1'b1, 4'd1, 1'b0, 1'b0);
    idle(BLINK - 1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle(10);

    // reset mid-on, then a clean burst
    step(1'b1, 4'd2, 1'b0, 1'b0);
    idle($urandom_range(10, 990));
    step(1'b0, 4'd0, 1'b0, 1'b1);
    idle(20);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    idle(BLINK + 10);

    // maximum count, cut short
    step(1'b1, 4'd15, 1'b0, 1'b0);
    idle($urandom_range(5000, 15000));
    step(1'b0, 4'd0, 1'b1, 1'b0);
    idle(5);

    // random traffic
    for (int i = 0; i < 25000; i++) begin
      step(1'($urandom_range(0, 199) == 0),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 7999) == 0),
           1'($urandom_range(0, 19999) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
